// File: rtl/rs_issue_scheduler_if.sv
`default_nettype none
// ============================================================================
// Module      : rs_issue_scheduler_if
// Description : Bundle between the RS table / issue stage (master) and the
//               issue scheduler (slave): ready/FU info in, issue slots out.
// Revision    : 1.0 - initial release
// ============================================================================
interface rs_issue_scheduler_if #(
    parameter int RSLEN = 16,
    parameter int IDXW  = $clog2(RSLEN)
);
    logic                   squash;
    logic [RSLEN-1:0]       entry_ready;
    logic [2*RSLEN-1:0]     entry_fu;
    logic                   mem_fu_ready;
    logic [2:0]             issue_valid;
    logic [3*IDXW-1:0]      issue_idx;
    logic [5:0]             issue_fu;
    logic [RSLEN-1:0]       issue_clear;
    logic                   mult_busy;

    modport master (
        output squash, entry_ready, entry_fu, mem_fu_ready,
        input  issue_valid, issue_idx, issue_fu, issue_clear, mult_busy
    );

    modport slave (
        input  squash, entry_ready, entry_fu, mem_fu_ready,
        output issue_valid, issue_idx, issue_fu, issue_clear, mult_busy
    );
endinterface
`default_nettype wire

// File: rtl/rs_issue_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : rs_issue_scheduler
// Description : Round-robin selection of up to 3 ready RS entries per cycle
//               onto NUM_ALU ALUs, one non-pipelined multiplier, one memory
//               port and one branch unit. All outputs registered.
// Revision    : 1.0 - initial release
// ============================================================================
module rs_issue_scheduler #(
    parameter int RSLEN    = 16,
    parameter int IDXW     = $clog2(RSLEN),
    parameter int NUM_ALU  = 3,
    parameter int MULT_LAT = 4
) (
    input  wire logic            clock,
    input  wire logic            reset,
    rs_issue_scheduler_if.slave  bus
);
    localparam int                c_cnt_w       = (MULT_LAT > 1) ? $clog2(MULT_LAT) : 1;
    localparam logic [c_cnt_w-1:0] c_mult_reload = c_cnt_w'(MULT_LAT - 1);
    localparam logic [1:0]        c_fu_alu      = 2'd0;
    localparam logic [1:0]        c_fu_mult     = 2'd1;
    localparam logic [1:0]        c_fu_mem      = 2'd2;

    logic [2:0]             issue_valid_q, issue_valid_d;
    logic [3*IDXW-1:0]      issue_idx_q,   issue_idx_d;
    logic [5:0]             issue_fu_q,    issue_fu_d;
    logic [RSLEN-1:0]       issue_clear_q, issue_clear_d;
    logic                   mult_busy_q,   mult_busy_d;
    logic [IDXW-1:0]        rr_ptr_q,      rr_ptr_d;
    logic [c_cnt_w-1:0]     mult_cnt_q,    mult_cnt_d;

    logic [RSLEN-1:0]       eligible;
    logic [IDXW:0]          scan_sum;
    logic [IDXW-1:0]        scan_idx;
    logic [IDXW-1:0]        last_idx;
    logic [1:0]             scan_fu;
    logic [1:0]             n_total;
    logic [1:0]             n_alu;
    logic                   mult_taken;
    logic                   mem_taken;
    logic                   br_taken;
    logic                   can_grant;

    // Entries granted last edge are still being freed by the RS; skip them.
    assign eligible = bus.entry_ready & ~issue_clear_q;

    // Round-robin scan from rr_ptr, granting entries that fit the FU budget.
    always_comb begin
        issue_valid_d = '0;
        issue_idx_d   = '0;
        issue_fu_d    = '0;
        issue_clear_d = '0;
        n_total       = '0;
        n_alu         = '0;
        mult_taken    = 1'b0;
        mem_taken     = 1'b0;
        br_taken      = 1'b0;
        last_idx      = rr_ptr_q;
        scan_sum      = '0;
        scan_idx      = '0;
        scan_fu       = '0;
        can_grant     = 1'b0;
        for (int k = 0; k < RSLEN; k++) begin
            scan_sum = {1'b0, rr_ptr_q} + (IDXW+1)'(k);
            if (scan_sum >= (IDXW+1)'(RSLEN)) begin
                scan_sum = scan_sum - (IDXW+1)'(RSLEN);
            end
            scan_idx = scan_sum[IDXW-1:0];
            scan_fu  = bus.entry_fu[2*scan_idx +: 2];
            case (scan_fu)
                c_fu_alu:  can_grant = (n_alu < 2'(NUM_ALU));
                c_fu_mult: can_grant = !mult_taken && (mult_cnt_q == '0);
                c_fu_mem:  can_grant = !mem_taken && bus.mem_fu_ready;
                default:   can_grant = !br_taken;
            endcase
            if (eligible[scan_idx] && (n_total < 2'd3) && can_grant) begin
                issue_valid_d[n_total]              = 1'b1;
                issue_idx_d[n_total*IDXW +: IDXW]   = scan_idx;
                issue_fu_d[n_total*2 +: 2]          = scan_fu;
                issue_clear_d[scan_idx]             = 1'b1;
                last_idx                            = scan_idx;
                n_total                             = n_total + 2'd1;
                case (scan_fu)
                    c_fu_alu:  n_alu      = n_alu + 2'd1;
                    c_fu_mult: mult_taken = 1'b1;
                    c_fu_mem:  mem_taken  = 1'b1;
                    default:   br_taken   = 1'b1;
                endcase
            end
        end

        // Pointer moves just past the last granted entry, wrapping at RSLEN.
        rr_ptr_d = rr_ptr_q;
        if (n_total != 2'd0) begin
            rr_ptr_d = (last_idx == IDXW'(RSLEN - 1)) ? '0 : last_idx + IDXW'(1);
        end

        if (mult_taken) begin
            mult_cnt_d = c_mult_reload;
        end else if (mult_cnt_q != '0) begin
            mult_cnt_d = mult_cnt_q - c_cnt_w'(1);
        end else begin
            mult_cnt_d = mult_cnt_q;
        end

        // Squash discards this cycle's selection and restarts arbitration.
        if (bus.squash) begin
            issue_valid_d = '0;
            issue_idx_d   = '0;
            issue_fu_d    = '0;
            issue_clear_d = '0;
            rr_ptr_d      = '0;
            mult_cnt_d    = '0;
        end

        mult_busy_d = (mult_cnt_d != '0);
    end

    // Register all outputs and arbitration state; reset dominates squash.
    always_ff @(posedge clock) begin
        if (reset) begin
            issue_valid_q <= '0;
            issue_idx_q   <= '0;
            issue_fu_q    <= '0;
            issue_clear_q <= '0;
            mult_busy_q   <= 1'b0;
            rr_ptr_q      <= '0;
            mult_cnt_q    <= '0;
        end else begin
            issue_valid_q <= issue_valid_d;
            issue_idx_q   <= issue_idx_d;
            issue_fu_q    <= issue_fu_d;
            issue_clear_q <= issue_clear_d;
            mult_busy_q   <= mult_busy_d;
            rr_ptr_q      <= rr_ptr_d;
            mult_cnt_q    <= mult_cnt_d;
        end
    end

    assign bus.issue_valid = issue_valid_q;
    assign bus.issue_idx   = issue_idx_q;
    assign bus.issue_fu    = issue_fu_q;
    assign bus.issue_clear = issue_clear_q;
    assign bus.mult_busy   = mult_busy_q;

endmodule
`default_nettype wire

// File: tb/tb_rs_issue_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_rs_issue_scheduler
// Description : Directed scenarios plus random traffic for rs_issue_scheduler,
//               compared against a queue-based reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rs_issue_scheduler;
    localparam int RSLEN    = 16;
    localparam int IDXW     = 4;
    localparam int NUM_ALU  = 3;
    localparam int MULT_LAT = 4;

    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    rs_issue_scheduler_if #(.RSLEN(RSLEN), .IDXW(IDXW)) bus ();

    rs_issue_scheduler #(
        .RSLEN(RSLEN), .IDXW(IDXW), .NUM_ALU(NUM_ALU), .MULT_LAT(MULT_LAT)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    int n_chk = 0;
    int n_bad = 0;

    // reference model state and expected outputs
    int                 m_rr;
    int                 m_cnt;
    logic [RSLEN-1:0]   m_clear;
    logic [2:0]         e_valid;
    logic [3*IDXW-1:0]  e_idx;
    logic [5:0]         e_fu;
    logic               e_busy;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        n_chk++;
        if (obs !== exp_v) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp_v, $time);
        end
    endtask

    task automatic model_clear_all();
        m_rr    = 0;
        m_cnt   = 0;
        m_clear = '0;
        e_valid = '0;
        e_idx   = '0;
        e_fu    = '0;
        e_busy  = 1'b0;
    endtask

    // One clock edge of the scheduler, from the rules: walk entries in
    // rotating order and take those the FU pool can still accept.
    task automatic model_edge();
        int got[$];
        int n_alu;
        bit gm, gmem, gbr, ok;
        int i, t;
        if (reset || bus.squash) begin
            model_clear_all();
        end else begin
            n_alu = 0; gm = 0; gmem = 0; gbr = 0;
            for (int k = 0; k < RSLEN; k++) begin
                i = (m_rr + k) % RSLEN;
                t = int'(bus.entry_fu[2*i +: 2]);
                if (bus.entry_ready[i] && !m_clear[i] && got.size() < 3) begin
                    case (t)
                        0:       ok = (n_alu < NUM_ALU);
                        1:       ok = !gm && (m_cnt == 0);
                        2:       ok = !gmem && bus.mem_fu_ready;
                        default: ok = !gbr;
                    endcase
                    if (ok) begin
                        got.push_back(i);
                        if (t == 0) n_alu++;
                        if (t == 1) gm = 1;
                        if (t == 2) gmem = 1;
                        if (t == 3) gbr = 1;
                    end
                end
            end
            e_valid = '0; e_idx = '0; e_fu = '0; m_clear = '0;
            foreach (got[s]) begin
                e_valid[s]                = 1'b1;
                e_idx[s*IDXW +: IDXW]     = IDXW'(got[s]);
                e_fu[s*2 +: 2]            = bus.entry_fu[2*got[s] +: 2];
                m_clear[got[s]]           = 1'b1;
            end
            m_cnt  = gm ? (MULT_LAT - 1) : ((m_cnt > 0) ? m_cnt - 1 : 0);
            if (got.size() > 0) m_rr = (got[got.size()-1] + 1) % RSLEN;
            e_busy = (m_cnt != 0);
        end
    endtask

    task automatic step(input logic rst, input logic sq, input logic [RSLEN-1:0] rdy,
                        input logic [2*RSLEN-1:0] fu, input logic mrdy);
        reset            = rst;
        bus.squash       = sq;
        bus.entry_ready  = rdy;
        bus.entry_fu     = fu;
        bus.mem_fu_ready = mrdy;
        @(posedge clock);
        model_edge();
        #1;
        chk("valid", 64'(bus.issue_valid), 64'(e_valid));
        chk("idx",   64'(bus.issue_idx),   64'(e_idx));
        chk("fu",    64'(bus.issue_fu),    64'(e_fu));
        chk("clear", 64'(bus.issue_clear), 64'(m_clear));
        chk("busy",  64'(bus.mult_busy),   64'(e_busy));
    endtask

    initial begin
        logic [RSLEN-1:0]   r_rdy;
        logic [2*RSLEN-1:0] r_fu;
        model_clear_all();

        // reset held with everything ready
        repeat (2) begin
            step(1'b1, 1'b0, 16'hFFFF, '0, 1'b1);
            chk("rst_valid", 64'(bus.issue_valid), 64'd0);
            chk("rst_clear", 64'(bus.issue_clear), 64'd0);
            chk("rst_busy",  64'(bus.mult_busy),   64'd0);
        end

        // ALU width limit, then mask of just-issued entries
        step(1'b0, 1'b0, 16'h000F, '0, 1'b1);
        chk("alu_idx",   64'(bus.issue_idx),   64'h210);
        chk("alu_clear", 64'(bus.issue_clear), 64'h0007);
        step(1'b0, 1'b0, 16'h000F, '0, 1'b1);
        chk("alu2_valid", 64'(bus.issue_valid), 64'h1);
        chk("alu2_idx",   64'(bus.issue_idx),   64'h003);
        chk("alu2_clear", 64'(bus.issue_clear), 64'h0008);
        step(1'b0, 1'b0, 16'h0000, '0, 1'b1);
        chk("empty_valid", 64'(bus.issue_valid), 64'h0);

        // multiplier spacing
        step(1'b0, 1'b1, 16'h0000, '0, 1'b1);
        step(1'b0, 1'b0, 16'h0060, 32'h0000_1400, 1'b1);
        chk("mul_k_idx",  64'(bus.issue_idx), 64'h005);
        chk("mul_k_busy", 64'(bus.mult_busy), 64'h1);
        repeat (3) begin
            step(1'b0, 1'b0, 16'h0060, 32'h0000_1400, 1'b1);
            chk("mul_gap_valid", 64'(bus.issue_valid), 64'h0);
        end
        step(1'b0, 1'b0, 16'h0060, 32'h0000_1400, 1'b1);
        chk("mul_k4_valid", 64'(bus.issue_valid), 64'h1);
        chk("mul_k4_idx",   64'(bus.issue_idx),   64'h006);

        // memory backpressure
        step(1'b0, 1'b1, 16'h0000, '0, 1'b1);
        repeat (3) begin
            step(1'b0, 1'b0, 16'h0004, 32'h0000_0020, 1'b0);
            chk("mem_blk_valid", 64'(bus.issue_valid), 64'h0);
        end
        step(1'b0, 1'b0, 16'h0004, 32'h0000_0020, 1'b1);
        chk("mem_valid", 64'(bus.issue_valid), 64'h1);
        chk("mem_fu",    64'(bus.issue_fu),    64'h02);
        chk("mem_idx",   64'(bus.issue_idx),   64'h002);

        // round-robin wrap: park pointer at 14, then entries 15 and 1
        step(1'b0, 1'b1, 16'h0000, '0, 1'b1);
        step(1'b0, 1'b0, 16'h2000, '0, 1'b1);
        step(1'b0, 1'b0, 16'h8002, '0, 1'b1);
        chk("wrap_idx",   64'(bus.issue_idx),   64'h01F);
        chk("wrap_clear", 64'(bus.issue_clear), 64'h8002);
        step(1'b0, 1'b0, 16'h0005, '0, 1'b1);
        chk("wrap_rr_idx", 64'(bus.issue_idx), 64'h002);

        // squash right after a multiply issue
        step(1'b0, 1'b1, 16'h0000, '0, 1'b1);
        step(1'b0, 1'b0, 16'h0020, 32'h0000_0400, 1'b1);
        chk("sq_mul_idx", 64'(bus.issue_idx), 64'h005);
        step(1'b0, 1'b1, 16'h0080, 32'h0000_4000, 1'b1);
        chk("sq_valid", 64'(bus.issue_valid), 64'h0);
        chk("sq_busy",  64'(bus.mult_busy),   64'h0);
        step(1'b0, 1'b0, 16'h0080, 32'h0000_4000, 1'b1);
        chk("sq_new_valid", 64'(bus.issue_valid), 64'h1);
        chk("sq_new_idx",   64'(bus.issue_idx),   64'h007);

        // random traffic against the model
        for (int n = 0; n < 600; n++) begin
            r_rdy = RSLEN'($urandom & $urandom);
            if ($urandom_range(0, 3) == 0) r_rdy = RSLEN'($urandom);
            r_fu  = (2*RSLEN)'($urandom);
            step(($urandom_range(0, 200) == 0), ($urandom_range(0, 40) == 0),
                 r_rdy, r_fu, ($urandom_range(0, 3) != 0));
        end

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end
endmodule
`default_nettype wire
